// File: rtl/axi_burst_ram_slave.sv
// AXI4 slave terminating a master port onto a word-addressed RAM.
// One outstanding burst per direction; INCR and FIXED 32-bit bursts only, all else answers SLVERR.
module axi_burst_ram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  s_axi_awid,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [3:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_arid,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [3:0]  s_axi_rid,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int unsigned IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic inRange(input logic [31:0] addr);
    logic [32:0] diff;
    diff = {1'b0, addr} - {1'b0, BASE_ADDR};
    return !diff[32] && ((diff[31:0] >> 2) < 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [IDXW-1:0] wordIdx(input logic [31:0] addr);
    return IDXW'((addr - BASE_ADDR) >> 2);
  endfunction

  function automatic logic beatLegal(input logic [31:0] addr, input logic [1:0] burst,
                                     input logic [2:0] size);
    return inRange(addr) && !burst[1] && (size == 3'b010);
  endfunction

  function automatic logic [31:0] nextAddr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == 2'b01) ? addr + 32'd4 : addr;
  endfunction

  wstate_e     wState_q, wState_d;
  logic [3:0]  awId_q, awId_d;
  logic [31:0] awAddr_q, awAddr_d;
  logic [7:0]  awLen_q, awLen_d;
  logic [1:0]  awBurst_q, awBurst_d;
  logic [2:0]  awSize_q, awSize_d;
  logic [8:0]  wCnt_q, wCnt_d;
  logic        wErr_q, wErr_d;
  logic        wWrEn;

  rstate_e     rState_q, rState_d;
  logic [3:0]  arId_q, arId_d;
  logic [31:0] arAddr_q, arAddr_d;
  logic [7:0]  arLen_q, arLen_d;
  logic [1:0]  arBurst_q, arBurst_d;
  logic [2:0]  arSize_q, arSize_d;
  logic [8:0]  rCnt_q, rCnt_d;
  logic [31:0] rData_q, rData_d;
  logic [1:0]  rResp_q, rResp_d;
  logic        rLast_q, rLast_d;

  always_comb begin
    wState_d  = wState_q;
    awId_d    = awId_q;
    awAddr_d  = awAddr_q;
    awLen_d   = awLen_q;
    awBurst_d = awBurst_q;
    awSize_d  = awSize_q;
    wCnt_d    = wCnt_q;
    wErr_d    = wErr_q;
    wWrEn     = 1'b0;
    unique case (wState_q)
      W_IDLE: begin
        if (s_axi_awvalid) begin
          awId_d    = s_axi_awid;
          awAddr_d  = s_axi_awaddr;
          awLen_d   = s_axi_awlen;
          awBurst_d = s_axi_awburst;
          awSize_d  = s_axi_awsize;
          wCnt_d    = 9'd0;
          wErr_d    = 1'b0;
          wState_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          if (beatLegal(awAddr_q, awBurst_q, awSize_q)) wWrEn = !rst;
          else wErr_d = 1'b1;
          awAddr_d = nextAddr(awAddr_q, awBurst_q);
          wCnt_d   = wCnt_q + 9'd1;
          // A burst whose wlast disagrees with awlen still completes, but is flagged.
          if (s_axi_wlast) begin
            wState_d = W_RESP;
            if (wCnt_q != {1'b0, awLen_q}) wErr_d = 1'b1;
          end else if (wCnt_q >= {1'b0, awLen_q}) begin
            wErr_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase
  end

  always_comb begin
    rState_d  = rState_q;
    arId_d    = arId_q;
    arAddr_d  = arAddr_q;
    arLen_d   = arLen_q;
    arBurst_d = arBurst_q;
    arSize_d  = arSize_q;
    rCnt_d    = rCnt_q;
    rData_d   = rData_q;
    rResp_d   = rResp_q;
    rLast_d   = rLast_q;
    unique case (rState_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          arId_d    = s_axi_arid;
          arAddr_d  = s_axi_araddr;
          arLen_d   = s_axi_arlen;
          arBurst_d = s_axi_arburst;
          arSize_d  = s_axi_arsize;
          rCnt_d    = 9'd0;
          rState_d  = R_FETCH;
        end
      end
      R_FETCH: begin
        // RAM is read at this edge only, so the beat stays frozen through R_DATA stalls.
        if (beatLegal(arAddr_q, arBurst_q, arSize_q)) begin
          rData_d = mem[wordIdx(arAddr_q)];
          rResp_d = 2'b00;
        end else begin
          rData_d = 32'd0;
          rResp_d = 2'b10;
        end
        rLast_d  = (rCnt_q == {1'b0, arLen_q});
        rState_d = R_DATA;
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rLast_q) begin
            rState_d = R_IDLE;
          end else begin
            arAddr_d = nextAddr(arAddr_q, arBurst_q);
            rCnt_d   = rCnt_q + 9'd1;
            rState_d = R_FETCH;
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wState_q  <= W_IDLE;
      awId_q    <= '0;
      awAddr_q  <= '0;
      awLen_q   <= '0;
      awBurst_q <= '0;
      awSize_q  <= '0;
      wCnt_q    <= '0;
      wErr_q    <= 1'b0;
      rState_q  <= R_IDLE;
      arId_q    <= '0;
      arAddr_q  <= '0;
      arLen_q   <= '0;
      arBurst_q <= '0;
      arSize_q  <= '0;
      rCnt_q    <= '0;
      rData_q   <= '0;
      rResp_q   <= '0;
      rLast_q   <= 1'b0;
    end else begin
      wState_q  <= wState_d;
      awId_q    <= awId_d;
      awAddr_q  <= awAddr_d;
      awLen_q   <= awLen_d;
      awBurst_q <= awBurst_d;
      awSize_q  <= awSize_d;
      wCnt_q    <= wCnt_d;
      wErr_q    <= wErr_d;
      rState_q  <= rState_d;
      arId_q    <= arId_d;
      arAddr_q  <= arAddr_d;
      arLen_q   <= arLen_d;
      arBurst_q <= arBurst_d;
      arSize_q  <= arSize_d;
      rCnt_q    <= rCnt_d;
      rData_q   <= rData_d;
      rResp_q   <= rResp_d;
      rLast_q   <= rLast_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wWrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) mem[wordIdx(awAddr_q)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_awready = (wState_q == W_IDLE) && !rst;
  assign s_axi_wready  = (wState_q == W_DATA);
  assign s_axi_bvalid  = (wState_q == W_RESP);
  assign s_axi_bid     = awId_q;
  assign s_axi_bresp   = (s_axi_bvalid && wErr_q) ? 2'b10 : 2'b00;

  assign s_axi_arready = (rState_q == R_IDLE) && !rst;
  assign s_axi_rvalid  = (rState_q == R_DATA);
  assign s_axi_rid     = arId_q;
  assign s_axi_rdata   = rData_q;
  assign s_axi_rresp   = rResp_q;
  assign s_axi_rlast   = rLast_q;

endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Self-checking bench for axi_burst_ram_slave: directed and random bursts
// compared against a byte-level memory model of the slave's rules.
module tb_axi_burst_ram_slave;

  localparam int DEPTH = 1024;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  always #5 clk = ~clk;

  axi_burst_ram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] refMem [DEPTH];
  logic [31:0] wData [256];
  logic [3:0]  wStrb [256];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: each beat lands at start+4*i (INCR) or start (FIXED) if legal and inside the RAM.
  function automatic logic [1:0] refWrite(input logic [31:0] addr, input int len,
                                          input logic [1:0] burst, input logic [2:0] size,
                                          input int nBeats);
    logic [31:0] a;
    bit err;
    err = (nBeats != len + 1);
    for (int i = 0; i < nBeats; i++) begin
      a = (burst == 2'b01) ? addr + 32'(4 * i) : addr;
      if (burst[1] || size != 3'b010 || a >= 32'(DEPTH * 4)) err = 1'b1;
      else
        for (int b = 0; b < 4; b++)
          if (wStrb[i][b]) refMem[a[11:2]][8*b +: 8] = wData[i][8*b +: 8];
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic axiWrite(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input int nBeats, input int bStall);
    logic [1:0] expResp;
    int t;
    expResp = refWrite(addr, len, burst, size, nBeats);
    @(negedge clk);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awburst = burst; s_axi_awsize = size; s_axi_awvalid = 1'b1;
    t = 0;
    while (s_axi_awready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin checkOutput("awready_timeout", 0, 1); s_axi_awvalid = 1'b0; return; end
    @(posedge clk); @(negedge clk);
    s_axi_awvalid = 1'b0;
    checkOutput("awready_busy", 32'(s_axi_awready), 0);
    for (int i = 0; i < nBeats; i++) begin
      s_axi_wdata = wData[i]; s_axi_wstrb = wStrb[i];
      s_axi_wlast = (i == nBeats - 1); s_axi_wvalid = 1'b1;
      t = 0;
      while (s_axi_wready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin checkOutput("wready_timeout", 0, 1); s_axi_wvalid = 1'b0; return; end
      @(posedge clk); @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    for (int s = 0; s < bStall; s++) begin
      checkOutput("bvalid_held", 32'(s_axi_bvalid), 1);
      checkOutput("awready_stall", 32'(s_axi_awready), 0);
      @(negedge clk);
    end
    t = 0;
    while (s_axi_bvalid !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin checkOutput("bvalid_timeout", 0, 1); return; end
    checkOutput("bresp", 32'(s_axi_bresp), 32'(expResp));
    checkOutput("bid", 32'(s_axi_bid), 32'(id));
    s_axi_bready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_axi_bready = 1'b0;
    checkOutput("bvalid_clear", 32'(s_axi_bvalid), 0);
    checkOutput("awready_after_b", 32'(s_axi_awready), 1);
  endtask

  task automatic axiRead(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size,
                         input int stall, input bit chkLat);
    logic [31:0] a, expD;
    logic [1:0]  expR;
    int t;
    @(negedge clk);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arburst = burst; s_axi_arsize = size; s_axi_arvalid = 1'b1;
    t = 0;
    while (s_axi_arready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin checkOutput("arready_timeout", 0, 1); s_axi_arvalid = 1'b0; return; end
    @(posedge clk); @(negedge clk);
    s_axi_arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a = (burst == 2'b01) ? addr + 32'(4 * i) : addr;
      if (!burst[1] && size == 3'b010 && a < 32'(DEPTH * 4)) begin
        expD = refMem[a[11:2]]; expR = 2'b00;
      end else begin
        expD = 32'd0; expR = 2'b10;
      end
      t = 0;
      while (s_axi_rvalid !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin checkOutput("rvalid_timeout", 0, 1); return; end
      if (chkLat) checkOutput("rvalid_gap", t, 1);
      for (int s = 0; s < ((i % 2 == 1) ? stall : 0); s++) begin
        checkOutput("stall_rvalid", 32'(s_axi_rvalid), 1);
        checkOutput("stall_rdata", s_axi_rdata, expD);
        checkOutput("stall_rlast", 32'(s_axi_rlast), 32'(i == len));
        @(negedge clk);
      end
      checkOutput("rdata", s_axi_rdata, expD);
      checkOutput("rresp", 32'(s_axi_rresp), 32'(expR));
      checkOutput("rlast", 32'(s_axi_rlast), 32'(i == len));
      checkOutput("rid", 32'(s_axi_rid), 32'(id));
      s_axi_rready = 1'b1;
      @(posedge clk); @(negedge clk);
      s_axi_rready = 1'b0;
    end
    checkOutput("rvalid_done", 32'(s_axi_rvalid), 0);
    checkOutput("arready_idle", 32'(s_axi_arready), 1);
  endtask

  initial begin
    int t;
    int ln, wd;
    logic [1:0] bst;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = 32'd0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_awready", 32'(s_axi_awready), 0);
    checkOutput("rst_arready", 32'(s_axi_arready), 0);
    checkOutput("rst_wready", 32'(s_axi_wready), 0);
    checkOutput("rst_bvalid", 32'(s_axi_bvalid), 0);
    checkOutput("rst_rvalid", 32'(s_axi_rvalid), 0);
    checkOutput("rst_rdata", s_axi_rdata, 0);
    checkOutput("rst_rlast", 32'(s_axi_rlast), 0);
    checkOutput("rst_bid", 32'(s_axi_bid), 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_awready", 32'(s_axi_awready), 1);
    checkOutput("post_rst_arready", 32'(s_axi_arready), 1);

    // Preload the low 256 words with a maximum-length burst.
    for (int i = 0; i < 256; i++) begin wData[i] = $urandom; wStrb[i] = 4'hF; end
    axiWrite(4'h7, 32'h0, 255, 2'b01, 3'b010, 256, 0);

    for (int i = 0; i < 4; i++) begin wData[i] = 32'h1111_1111 * (i + 1); wStrb[i] = 4'hF; end
    axiWrite(4'h5, 32'h40, 3, 2'b01, 3'b010, 4, 0);
    axiRead(4'h9, 32'h40, 3, 2'b01, 3'b010, 0, 1'b1);

    wData[0] = 32'hAABB_CCDD; wStrb[0] = 4'hF;
    axiWrite(4'h1, 32'h80, 0, 2'b01, 3'b010, 1, 0);
    wData[0] = 32'h0000_0011; wStrb[0] = 4'b0001;
    axiWrite(4'h2, 32'h80, 0, 2'b01, 3'b010, 1, 0);
    axiRead(4'h3, 32'h80, 0, 2'b01, 3'b010, 0, 1'b1);

    wData[0] = 32'hAAAA_0001; wData[1] = 32'hBBBB_0002; wData[2] = 32'hCCCC_0003;
    for (int i = 0; i < 3; i++) wStrb[i] = 4'hF;
    axiWrite(4'h4, 32'h10, 2, 2'b00, 3'b010, 3, 0);
    axiRead(4'h4, 32'h10, 0, 2'b01, 3'b010, 0, 1'b1);
    axiRead(4'hA, 32'h10, 3, 2'b10, 3'b010, 0, 1'b1);

    wData[0] = 32'hDEAD_0FFC; wData[1] = 32'hDEAD_1000; wStrb[0] = 4'hF; wStrb[1] = 4'hF;
    axiWrite(4'hB, 32'h0000_0FFC, 1, 2'b01, 3'b010, 2, 0);
    axiRead(4'hC, 32'h0000_0FFC, 1, 2'b01, 3'b010, 0, 1'b1);
    axiRead(4'hD, 32'h0000_1000, 0, 2'b01, 3'b010, 0, 1'b1);

    // Illegal size, WRAP, early wlast and late wlast all complete with SLVERR.
    wData[0] = 32'h5555_AAAA; wStrb[0] = 4'hF;
    axiWrite(4'h6, 32'h140, 0, 2'b01, 3'b011, 1, 0);
    axiWrite(4'h6, 32'h144, 0, 2'b10, 3'b010, 1, 0);
    axiRead(4'h6, 32'h140, 1, 2'b01, 3'b011, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin wData[i] = $urandom; wStrb[i] = 4'hF; end
    axiWrite(4'h8, 32'h100, 3, 2'b01, 3'b010, 2, 0);
    axiWrite(4'h8, 32'h120, 1, 2'b01, 3'b010, 3, 0);
    axiRead(4'h8, 32'h100, 1, 2'b01, 3'b010, 0, 1'b0);
    axiRead(4'h8, 32'h120, 2, 2'b01, 3'b010, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin wData[i] = $urandom; wStrb[i] = 4'hF; end
    axiWrite(4'hE, 32'h180, 3, 2'b01, 3'b010, 4, 5);
    axiRead(4'hF, 32'h180, 3, 2'b01, 3'b010, 2, 1'b0);

    for (int i = 0; i < 8; i++) begin wData[i] = $urandom; wStrb[i] = 4'($urandom); end
    fork
      axiWrite(4'h1, 32'h200, 7, 2'b01, 3'b010, 8, 0);
      axiRead(4'h2, 32'h000, 7, 2'b01, 3'b010, 0, 1'b0);
    join
    axiRead(4'h3, 32'h200, 7, 2'b01, 3'b010, 0, 1'b0);

    // Reset lands while beat 2 of an 8-beat read is being presented.
    @(negedge clk);
    s_axi_arid = 4'h3; s_axi_araddr = 32'h40; s_axi_arlen = 8'd7;
    s_axi_arburst = 2'b01; s_axi_arsize = 3'b010; s_axi_arvalid = 1'b1;
    t = 0;
    while (s_axi_arready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    @(posedge clk); @(negedge clk);
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      while (s_axi_rvalid !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) checkOutput("rst_burst_timeout", 0, 1);
      if (i < 2) begin
        s_axi_rready = 1'b1;
        @(posedge clk); @(negedge clk);
        s_axi_rready = 1'b0;
      end
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("midrst_rvalid", 32'(s_axi_rvalid), 0);
    checkOutput("midrst_arready", 32'(s_axi_arready), 0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_arready_release", 32'(s_axi_arready), 1);
    axiRead(4'h5, 32'h44, 3, 2'b01, 3'b010, 0, 1'b1);

    for (int k = 0; k < 16; k++) begin
      ln  = int'($urandom_range(0, 7));
      wd  = int'($urandom_range(0, 255 - ln));
      bst = 2'($urandom_range(0, 1));
      for (int i = 0; i <= ln; i++) begin wData[i] = $urandom; wStrb[i] = 4'($urandom); end
      axiWrite(4'($urandom), 32'(wd * 4), ln, bst, 3'b010, ln + 1, int'($urandom_range(0, 2)));
      axiRead(4'($urandom), 32'(wd * 4), ln, bst, 3'b010, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
